// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the DE0-Nano ADC SPI responder and its master.
package adc_spi_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 12;

    typedef logic [3:0]             bitcnt_t;
    typedef logic [2:0]             chan_t;
    typedef logic [SAMPLE_BITS-1:0] sample_t;
    typedef logic [FRAME_BITS-1:0]  frame_t;

    localparam bitcnt_t ADDR_FIRST_BIT = 4'd2;
    localparam bitcnt_t ADDR_LAST_BIT  = 4'd4;
    localparam bitcnt_t DATA_FIRST_BIT = 4'd4;

    typedef enum logic {
        IDLE,
        ACTIVE
    } resp_state_t;

    // Four leading zero bits, then DB11..DB0.
    function automatic frame_t to_frame(sample_t s);
        return {{DATA_FIRST_BIT{1'b0}}, s};
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI bus between the pedal's ADC master and the emulated ADC device.
interface adc_spi_responder_if;
    import adc_spi_pkg::*;

    logic sclk;
    logic cs_b;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output sclk, cs_b, din, input dout, dout_oe);
    modport slave  (input sclk, cs_b, din, output dout, dout_oe);

endinterface

// File: rtl/adc_spi_responder_sync_edge_det.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI device emulating the DE0-Nano 8-channel 12-bit ADC for loopback builds.
// Define ADC_RESP_STATS_EN to add frame_count / abort_count outputs.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    adc_spi_responder_if.slave  spi,
    input  logic                ch_wr_en,
    input  chan_t               ch_wr_addr,
    input  logic [DATA_W-1:0]   ch_wr_data,
    output chan_t               cur_ch,
    output logic                frame_done
`ifdef ADC_RESP_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [7:0]          abort_count
`endif
);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic din_s;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi.sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi.cs_b),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sclk path so din lines up with the detected edge.
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;

    always_comb begin
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], spi.din};
    end

    assign din_s = din_sync_q[SYNC_STAGES-1];

    logic [DATA_W-1:0] bank_q [NUM_CH];
    logic [DATA_W-1:0] bank_d [NUM_CH];

    always_comb begin
        bank_d = bank_q;
        if (ch_wr_en) bank_d[ch_wr_addr] = ch_wr_data;
    end

    resp_state_t state_q, state_d;
    bitcnt_t     bit_cnt_q, bit_cnt_d;
    frame_t      frame_q, frame_d;
    chan_t       addr_sr_q, addr_sr_d;
    chan_t       next_ch_q, next_ch_d;
    chan_t       cur_ch_q, cur_ch_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    sample_t     snap_next, snap_addr;

    // Narrow samples are left-aligned so DB11 is always the first data bit.
    assign snap_next = sample_t'(bank_q[next_ch_q]) << (SAMPLE_BITS - DATA_W);
    assign snap_addr = sample_t'(bank_q[addr_sr_q]) << (SAMPLE_BITS - DATA_W);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        addr_sr_d = addr_sr_q;
        next_ch_d = next_ch_q;
        cur_ch_d  = cur_ch_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                oe_d      = 1'b0;
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d  = ACTIVE;
                    frame_d  = to_frame(snap_next);
                    cur_ch_d = next_ch_q;
                    oe_d     = 1'b1;
                end
            end
            ACTIVE: begin
                // cs_b takes priority over a coincident sclk edge.
                if (cs_rise) begin
                    state_d   = IDLE;
                    oe_d      = 1'b0;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    if (bit_cnt_q >= ADDR_FIRST_BIT &&
                        bit_cnt_q <= ADDR_LAST_BIT)
                        addr_sr_d = {addr_sr_q[1:0], din_s};
                end else if (sclk_fall) begin
                    bit_cnt_d = bit_cnt_q + bitcnt_t'(1);
                    frame_d   = frame_q << 1;
                    if (&bit_cnt_q) begin
                        done_d    = 1'b1;
                        next_ch_d = addr_sr_q;
                        cur_ch_d  = addr_sr_q;
                        frame_d   = to_frame(snap_addr);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_sync_q <= '0;
            bank_q     <= '{default: '0};
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            addr_sr_q  <= '0;
            next_ch_q  <= '0;
            cur_ch_q   <= '0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            din_sync_q <= din_sync_d;
            bank_q     <= bank_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            addr_sr_q  <= addr_sr_d;
            next_ch_q  <= next_ch_d;
            cur_ch_q   <= cur_ch_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
        end
    end

    assign spi.dout    = oe_q & frame_q[FRAME_BITS-1];
    assign spi.dout_oe = oe_q;
    assign cur_ch      = cur_ch_q;
    assign frame_done  = done_q;

`ifdef ADC_RESP_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;
    logic        abort;

    always_comb begin
        abort       = (state_q == ACTIVE) && cs_rise && (bit_cnt_q != '0);
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
        if (abort && abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder against a frame-level model of the ADC.
module tb_adc_spi_responder;
    import adc_spi_pkg::*;

    localparam int PH = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ch_wr_en = 1'b0;
    chan_t       ch_wr_addr = '0;
    logic [11:0] ch_wr_data = '0;
    chan_t       cur_ch;
    logic        frame_done;
`ifdef ADC_RESP_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  abort_count;
`endif

    adc_spi_responder_if spi_if ();

    adc_spi_responder dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi_if),
        .ch_wr_en   (ch_wr_en),
        .ch_wr_addr (ch_wr_addr),
        .ch_wr_data (ch_wr_data),
        .cur_ch     (cur_ch),
        .frame_done (frame_done)
`ifdef ADC_RESP_STATS_EN
        ,
        .frame_count (frame_count),
        .abort_count (abort_count)
`endif
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [11:0] bank_m [8];
    chan_t       next_m;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        next_m = '0;
    endtask

    function automatic logic [15:0] exp_frame(input chan_t c);
        return {4'b0000, bank_m[c]};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        spi_if.cs_b = 1'b1;
        spi_if.sclk = 1'b1;
        spi_if.din = 1'b0;
        ch_wr_en = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(4);
        model_reset();
    endtask

    task automatic write_bank(input chan_t a, input logic [11:0] d);
        ch_wr_en = 1'b1;
        ch_wr_addr = a;
        ch_wr_data = d;
        tick(1);
        ch_wr_en = 1'b0;
        bank_m[a] = d;
    endtask

    task automatic cs_end();
        spi_if.cs_b = 1'b1;
        tick(PH);
        spi_if.sclk = 1'b1;
        tick(PH);
    endtask

    // Master side: sclk idles high; dout read before each fall, din set while low.
    task automatic run_frame(input chan_t addr, input int nfalls,
                             input int wr_k, input chan_t wr_a,
                             input logic [11:0] wr_d,
                             output logic [15:0] bits, output chan_t ch,
                             output int ndone, output int lat);
        bits = '0;
        ch = '0;
        ndone = 0;
        lat = 0;
        for (int k = 0; k < nfalls; k++) begin
            tick(PH);
            bits = {bits[14:0], spi_if.dout};
            if (k == 0) ch = cur_ch;
            spi_if.sclk = 1'b0;
            spi_if.din = (k == 1) ? addr[2] :
                         (k == 2) ? addr[1] :
                         (k == 3) ? addr[0] : 1'b0;
            for (int j = 0; j < PH; j++) begin
                if (k == wr_k && j == 0) begin
                    ch_wr_en = 1'b1;
                    ch_wr_addr = wr_a;
                    ch_wr_data = wr_d;
                end
                tick(1);
                ch_wr_en = 1'b0;
                if (frame_done) begin
                    ndone++;
                    lat = j + 1;
                end
            end
            if (nfalls == 16 || k < nfalls - 1) spi_if.sclk = 1'b1;
        end
        if (nfalls < 16) bits = bits << (16 - nfalls);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_if.cs_b = 1'b1;
        spi_if.sclk = 1'b1;
        spi_if.din = 1'b0;
        tick(1);
        nvec += 4;
        if (spi_if.dout !== 1'b0) begin
            nerr++; $display("FAIL reset_dout got %b exp 0", spi_if.dout);
        end
        if (spi_if.dout_oe !== 1'b0) begin
            nerr++; $display("FAIL reset_oe got %b exp 0", spi_if.dout_oe);
        end
        if (cur_ch !== 3'd0) begin
            nerr++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch);
        end
        if (frame_done !== 1'b0) begin
            nerr++; $display("FAIL reset_done got %b exp 0", frame_done);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        spi_if.cs_b = 1'b0;
        run_frame(3'd5, 16, -1, '0, '0, bits, ch, nd, lat);
        nvec += 5;
        if (bits !== 16'h0000) begin
            nerr++; $display("FAIL basic_bits got %h exp 0000", bits);
        end
        if (ch !== 3'd0) begin
            nerr++; $display("FAIL basic_ch got %0d exp 0", ch);
        end
        if (nd !== 1) begin
            nerr++; $display("FAIL basic_done_cnt got %0d exp 1", nd);
        end
        if (lat !== 3) begin
            nerr++; $display("FAIL basic_done_lat got %0d exp 3", lat);
        end
        next_m = 3'd5;
        cs_end();
        if (spi_if.dout_oe !== 1'b0) begin
            nerr++; $display("FAIL basic_oe_off got %b exp 0", spi_if.dout_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        chan_t addrs [2];
        addrs[0] = 3'd5;
        addrs[1] = 3'd2;
        write_bank(3'd5, 12'hA5C);
        spi_if.cs_b = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_frame(addrs[f], 16, -1, '0, '0, bits, ch, nd, lat);
            nvec += 3;
            if (bits !== exp_frame(next_m)) begin
                nerr++; $display("FAIL b2b_bits f%0d got %h exp %h", f, bits, exp_frame(next_m));
            end
            if (ch !== next_m) begin
                nerr++; $display("FAIL b2b_ch f%0d got %0d exp %0d", f, ch, next_m);
            end
            if (nd !== 1) begin
                nerr++; $display("FAIL b2b_done f%0d got %0d exp 1", f, nd);
            end
            next_m = addrs[f];
        end
        nvec++;
        if (bits !== 16'b0000_1010_0101_1100) begin
            nerr++; $display("FAIL b2b_a5c got %h exp 0a5c", bits);
        end
        cs_end();
    endtask

    task automatic test_abort();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        spi_if.cs_b = 1'b0;
        run_frame(3'd3, 7, -1, '0, '0, bits, ch, nd, lat);
        cs_end();
        nvec += 3;
        if (nd !== 0) begin
            nerr++; $display("FAIL abort_done got %0d exp 0", nd);
        end
        if (ch !== next_m) begin
            nerr++; $display("FAIL abort_ch got %0d exp %0d", ch, next_m);
        end
        if (spi_if.dout_oe !== 1'b0) begin
            nerr++; $display("FAIL abort_oe got %b exp 0", spi_if.dout_oe);
        end
        spi_if.cs_b = 1'b0;
        run_frame(3'd1, 16, -1, '0, '0, bits, ch, nd, lat);
        nvec += 2;
        if (ch !== next_m) begin
            nerr++; $display("FAIL abort_next_ch got %0d exp %0d", ch, next_m);
        end
        if (bits !== exp_frame(next_m)) begin
            nerr++; $display("FAIL abort_next_bits got %h exp %h", bits, exp_frame(next_m));
        end
        next_m = 3'd1;
        cs_end();
    endtask

    task automatic test_mid_write();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        logic [15:0] exp;
        write_bank(3'd3, 12'h35A);
        spi_if.cs_b = 1'b0;
        run_frame(3'd3, 16, -1, '0, '0, bits, ch, nd, lat);
        next_m = 3'd3;
        exp = exp_frame(3'd3);
        run_frame(3'd0, 16, 6, 3'd3, 12'hFFF, bits, ch, nd, lat);
        bank_m[3] = 12'hFFF;
        nvec += 2;
        if (bits !== exp || bits !== 16'h035A) begin
            nerr++; $display("FAIL midwr_old got %h exp %h", bits, exp);
        end
        if (ch !== 3'd3) begin
            nerr++; $display("FAIL midwr_ch got %0d exp 3", ch);
        end
        next_m = 3'd0;
        write_bank(3'd0, 12'h001);
        spi_if.cs_b = 1'b1;
        tick(PH);
        spi_if.cs_b = 1'b0;
        next_m = 3'd0;
        run_frame(3'd3, 16, -1, '0, '0, bits, ch, nd, lat);
        next_m = 3'd3;
        run_frame(3'd0, 16, -1, '0, '0, bits, ch, nd, lat);
        nvec++;
        if (bits !== 16'h0FFF) begin
            nerr++; $display("FAIL midwr_new got %h exp 0fff", bits);
        end
        next_m = 3'd0;
        cs_end();
    endtask

    task automatic test_reset_midframe();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        write_bank(3'd0, 12'h456);
        write_bank(3'd5, 12'h123);
        spi_if.cs_b = 1'b0;
        run_frame(3'd6, 16, -1, '0, '0, bits, ch, nd, lat);
        run_frame(3'd5, 9, -1, '0, '0, bits, ch, nd, lat);
        reset = 1'b1;
        spi_if.cs_b = 1'b1;
        spi_if.sclk = 1'b1;
        tick(1);
        nvec += 5;
        if (ch !== 3'd6) begin
            nerr++; $display("FAIL rstmid_pre_ch got %0d exp 6", ch);
        end
        if (spi_if.dout !== 1'b0) begin
            nerr++; $display("FAIL rstmid_dout got %b exp 0", spi_if.dout);
        end
        if (spi_if.dout_oe !== 1'b0) begin
            nerr++; $display("FAIL rstmid_oe got %b exp 0", spi_if.dout_oe);
        end
        if (cur_ch !== 3'd0) begin
            nerr++; $display("FAIL rstmid_cur_ch got %0d exp 0", cur_ch);
        end
        if (frame_done !== 1'b0) begin
            nerr++; $display("FAIL rstmid_done got %b exp 0", frame_done);
        end
        tick(3);
        reset = 1'b0;
        tick(4);
        model_reset();
        spi_if.cs_b = 1'b0;
        run_frame(3'd5, 16, -1, '0, '0, bits, ch, nd, lat);
        nvec++;
        if (bits !== 16'h0000) begin
            nerr++; $display("FAIL rstmid_bank0 got %h exp 0000", bits);
        end
        run_frame(3'd0, 16, -1, '0, '0, bits, ch, nd, lat);
        nvec += 2;
        if (bits !== 16'h0000) begin
            nerr++; $display("FAIL rstmid_bank5 got %h exp 0000", bits);
        end
        if (ch !== 3'd5) begin
            nerr++; $display("FAIL rstmid_ch got %0d exp 5", ch);
        end
        next_m = 3'd0;
        cs_end();
    endtask

    task automatic test_random();
        logic [15:0] bits, exp, mask;
        chan_t ch, ech, addr, wa;
        logic [11:0] wd;
        int nd, lat, nf, wk;
        bit in_sess, abrt;
        in_sess = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (!in_sess) begin
                spi_if.cs_b = 1'b0;
                in_sess = 1'b1;
            end
            addr = chan_t'($urandom_range(0, 7));
            abrt = ($urandom_range(0, 5) == 0);
            nf = abrt ? int'($urandom_range(1, 15)) : 16;
            wk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nf - 1)) : -1;
            wa = chan_t'($urandom_range(0, 7));
            wd = 12'($urandom);
            exp = exp_frame(next_m);
            ech = next_m;
            run_frame(addr, nf, wk, wa, wd, bits, ch, nd, lat);
            if (wk >= 0) bank_m[wa] = wd;
            mask = 16'hFFFF << (16 - nf);
            nvec += 3;
            if ((bits & mask) !== (exp & mask)) begin
                nerr++; $display("FAIL rnd_bits it%0d got %h exp %h nf %0d", it, bits, exp, nf);
            end
            if (ch !== ech) begin
                nerr++; $display("FAIL rnd_ch it%0d got %0d exp %0d", it, ch, ech);
            end
            if (nd !== (abrt ? 0 : 1)) begin
                nerr++; $display("FAIL rnd_done it%0d got %0d exp %0d", it, nd, abrt ? 0 : 1);
            end
            if (abrt) begin
                cs_end();
                in_sess = 1'b0;
                nvec++;
                if (spi_if.dout_oe !== 1'b0) begin
                    nerr++; $display("FAIL rnd_oe it%0d got %b exp 0", it, spi_if.dout_oe);
                end
            end else begin
                next_m = addr;
                if ($urandom_range(0, 3) == 0) begin
                    cs_end();
                    in_sess = 1'b0;
                end
            end
        end
        if (in_sess) cs_end();
    endtask

`ifdef ADC_RESP_STATS_EN
    task automatic test_stats();
        logic [15:0] bits;
        chan_t ch;
        int nd, lat;
        apply_reset();
        spi_if.cs_b = 1'b0;
        for (int f = 0; f < 3; f++)
            run_frame(chan_t'($urandom_range(0, 7)), 16, -1, '0, '0, bits, ch, nd, lat);
        cs_end();
        for (int a = 0; a < 2; a++) begin
            spi_if.cs_b = 1'b0;
            run_frame(3'd2, int'($urandom_range(1, 15)), -1, '0, '0, bits, ch, nd, lat);
            cs_end();
        end
        nvec += 2;
        if (frame_count !== 16'd3) begin
            nerr++; $display("FAIL stats_frames got %0d exp 3", frame_count);
        end
        if (abort_count !== 8'd2) begin
            nerr++; $display("FAIL stats_aborts got %0d exp 2", abort_count);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d vectors", nvec);
        $fatal(1, "timeout");
    end

    initial begin
        spi_if.cs_b = 1'b1;
        spi_if.sclk = 1'b1;
        spi_if.din = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_mid_write();
        test_reset_midframe();
        test_random();
`ifdef ADC_RESP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
